dco_nco_core: RTL and testbench

Parametrised digitally controlled oscillator core and successor to the fixed 8-bit DCO. A phase accumulator advances by (current_code+1) every clock, and the accumulator MSB is the oscillator output. New relative to the fixed DCO:
- handshaked code loading
- slew-limited frequency glide toward the target code
- lock indication and a wrap strobe

The block sits behind the TinyTapeout top wrapper; the wrapper drives code_in from ui_in and routes dco_out/lock/wrap to uo_out.

---
 rtl/dco_nco_core.sv | 178 +++++++++++++++++
 tb/tb_dco_nco_core.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_nco_core.sv
// dco_nco_core: parametrised digitally controlled oscillator core.
// A phase accumulator advances by (cur+1) every enabled clock; its MSB is the
// oscillator output. The current code glides toward a handshaked target code
// at a bounded slew rate, with lock and accumulator-wrap indications.
//
// Optional feature: define DCO_DITHER_EN to add an 8-bit LFSR whose LSB is
// added to the accumulator increment (spur spreading).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        block enable; low clears the accumulator and prescaler
//   code_in    requested frequency code
//   code_load  latch code_in as the new target (only while ena=1)
//   code_ack   one-cycle pulse after each accepted load
//   dco_out    oscillator output (accumulator MSB)
//   phase      current accumulator value
//   wrap       one-cycle pulse after an accumulator overflow
//   lock       high when current code equals target code (registered)
module dco_nco_core #(
    parameter int unsigned CODE_W     = 8,
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned SLEW_STEP  = 1,
    parameter int unsigned SLEW_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_load,
    output logic              code_ack,
    output logic              dco_out,
    output logic [ACC_W-1:0]  phase,
    output logic              wrap,
    output logic              lock
);

    localparam int unsigned PRESC_W = (SLEW_SHIFT > 0) ? SLEW_SHIFT : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SLEWING = 2'd1,
        ST_LOCKED  = 2'd2
    } mode_e;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CODE_W-1:0]  target_q, target_d;
    logic [CODE_W-1:0]  cur_q, cur_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               ack_q, ack_d;
    logic               wrap_q, wrap_d;
    logic               lock_q, lock_d;

    mode_e              mode_c;
    logic               tick_c;
    logic [CODE_W-1:0]  up_gap_c;
    logic [CODE_W-1:0]  dn_gap_c;
    logic [CODE_W-1:0]  cur_slew_c;
    logic [ACC_W-1:0]   inc_c;
    logic [ACC_W:0]     sum_c;

`ifdef DCO_DITHER_EN
    logic [7:0]         lfsr_q, lfsr_d;
    logic               lfsr_fb_c;
`endif

    // Operating mode: idle when disabled, otherwise slewing until cur meets target
    always_comb begin
        mode_c = ST_IDLE;
        if (ena) begin
            mode_c = (cur_q == target_q) ? ST_LOCKED : ST_SLEWING;
        end
    end

    // Slew tick when the prescaler wraps; every enabled clock if SLEW_SHIFT is 0
    always_comb begin
        tick_c = (SLEW_SHIFT == 0) ? 1'b1 : (presc_q == '1);
    end

    // Bounded step toward the target; clamps to the target so there is no overshoot
    always_comb begin
        up_gap_c   = target_q - cur_q;
        dn_gap_c   = cur_q - target_q;
        cur_slew_c = cur_q;
        if (cur_q < target_q) begin
            cur_slew_c = (32'(up_gap_c) > SLEW_STEP) ? cur_q + CODE_W'(SLEW_STEP) : target_q;
        end else if (cur_q > target_q) begin
            cur_slew_c = (32'(dn_gap_c) > SLEW_STEP) ? cur_q - CODE_W'(SLEW_STEP) : target_q;
        end
    end

    // Accumulator increment with one extra bit to capture the overflow
    always_comb begin
`ifdef DCO_DITHER_EN
        inc_c = ACC_W'(cur_q) + ACC_W'(1) + ACC_W'(lfsr_q[0]);
`else
        inc_c = ACC_W'(cur_q) + ACC_W'(1);
`endif
        sum_c = {1'b0, acc_q} + {1'b0, inc_c};
    end

`ifdef DCO_DITHER_EN
    // Fibonacci LFSR, taps 8,6,5,4 (maximal length 255)
    always_comb begin
        lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d    = lfsr_q;
        if (ena) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Next-state logic for accumulator, codes, prescaler and output strobes
    always_comb begin
        acc_d    = acc_q;
        target_d = target_q;
        cur_d    = cur_q;
        presc_d  = presc_q;
        ack_d    = 1'b0;
        wrap_d   = 1'b0;
        lock_d   = (cur_q == target_q);

        case (mode_c)
            ST_IDLE: begin
                acc_d   = '0;
                presc_d = '0;
            end
            default: begin
                acc_d   = sum_c[ACC_W-1:0];
                wrap_d  = sum_c[ACC_W];
                presc_d = (SLEW_SHIFT == 0) ? '0 : presc_q + PRESC_W'(1);
                // Tick compares against the old target; a same-cycle load applies next cycle
                if (mode_c == ST_SLEWING && tick_c) begin
                    cur_d = cur_slew_c;
                end
                if (code_load) begin
                    target_d = code_in;
                    ack_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            target_q <= '0;
            cur_q    <= '0;
            presc_q  <= '0;
            ack_q    <= 1'b0;
            wrap_q   <= 1'b0;
            lock_q   <= 1'b1;
        end else begin
            acc_q    <= acc_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            presc_q  <= presc_d;
            ack_q    <= ack_d;
            wrap_q   <= wrap_d;
            lock_q   <= lock_d;
        end
    end

    assign code_ack = ack_q;
    assign dco_out  = acc_q[ACC_W-1];
    assign phase    = acc_q;
    assign wrap     = wrap_q;
    assign lock     = lock_q;

endmodule

// File: tb/tb_dco_nco_core.sv
// tb_dco_nco_core: directed self-checking bench for dco_nco_core
// (CODE_W=8, ACC_W=12, SLEW_STEP=1, SLEW_SHIFT=2). The current code is
// observed indirectly as (phase delta - 1) between consecutive clocks.
// The dither scenario runs only when DCO_DITHER_EN is defined.
module tb_dco_nco_core;

    localparam int unsigned CODE_W     = 8;
    localparam int unsigned ACC_W      = 12;
    localparam int unsigned SLEW_STEP  = 1;
    localparam int unsigned SLEW_SHIFT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [CODE_W-1:0] code_in;
    logic              code_load;
    logic              code_ack;
    logic              dco_out;
    logic [ACC_W-1:0]  phase;
    logic              wrap;
    logic              lock;

    int n_checks = 0;
    int n_fail   = 0;

    dco_nco_core #(
        .CODE_W     (CODE_W),
        .ACC_W      (ACC_W),
        .SLEW_STEP  (SLEW_STEP),
        .SLEW_SHIFT (SLEW_SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .code_in   (code_in),
        .code_load (code_load),
        .code_ack  (code_ack),
        .dco_out   (dco_out),
        .phase     (phase),
        .wrap      (wrap),
        .lock      (lock)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock, returning the code that drove the accumulator during it
    task automatic step_obs(output int code);
        logic [ACC_W-1:0] p0;
        logic [ACC_W-1:0] d;
        p0 = phase;
        tick();
        d = phase - p0 - 12'd1;
        code = int'(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; code_load = 1'b0; code_in = '0;
        tick();
        n_checks++; if (phase !== 12'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_checks++; if (dco_out !== 1'b0) begin n_fail++; $display("FAIL reset_dco: got %b expected 0", dco_out); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        n_checks++; if (code_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", code_ack); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL reset_lock: got %b expected 1", lock); end
        rst_n = 1'b1;
        tick();
    endtask

    // Code 0 after reset: phase counts by 1, one wrap per 4096 clocks, 50% duty
    task automatic test_free_run(input string tag);
        int perr, werr, ones, wraps;
        perr = 0; werr = 0; ones = 0; wraps = 0;
        ena = 1'b1;
        for (int i = 1; i <= 4096; i++) begin
            tick();
            if (phase !== 12'(i)) perr++;
            if (dco_out === 1'b1) ones++;
            if (wrap === 1'b1) wraps++;
            if (wrap !== (i == 4096)) werr++;
        end
        n_checks++; if (perr !== 0) begin n_fail++; $display("FAIL %s_phase_step: got %0d bad steps expected 0", tag, perr); end
        n_checks++; if (werr !== 0) begin n_fail++; $display("FAIL %s_wrap_timing: got %0d bad cycles expected 0", tag, werr); end
        n_checks++; if (wraps !== 1) begin n_fail++; $display("FAIL %s_wrap_count: got %0d expected 1", tag, wraps); end
        n_checks++; if (ones !== 2048) begin n_fail++; $display("FAIL %s_dco_high: got %0d expected 2048", tag, ones); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL %s_lock: got %b expected 1", tag, lock); end
    endtask

    // Load 63 from code 0: ack, lock drop, glide, then 64-clock period
    task automatic test_load_slew();
        int lock_at, found, werr, ones, c;
        code_in = 8'd63; code_load = 1'b1;
        tick();
        n_checks++; if (code_ack !== 1'b1) begin n_fail++; $display("FAIL ack_pulse: got %b expected 1", code_ack); end
        code_load = 1'b0;
        tick();
        n_checks++; if (code_ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle: got %b expected 0", code_ack); end
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL lock_drop: got %b expected 0", lock); end
        lock_at = -1;
        for (int k = 2; k <= 400; k++) begin
            tick();
            if (lock === 1'b1) begin lock_at = k; break; end
        end
        // 63 ticks of 4 clocks, first tick 1..4 clocks after the load, lock one clock later
        n_checks++; if (lock_at < 250 || lock_at > 253) begin n_fail++; $display("FAIL slew_lock_time: got %0d expected 250..253", lock_at); end
        found = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (wrap === 1'b1) begin found = 1; break; end
        end
        n_checks++; if (found !== 1) begin n_fail++; $display("FAIL wrap_seen: got %0d expected 1", found); end
        werr = 0; ones = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (dco_out === 1'b1) ones++;
            if (wrap !== (i == 64)) werr++;
        end
        n_checks++; if (werr !== 0) begin n_fail++; $display("FAIL period64_wrap: got %0d bad cycles expected 0", werr); end
        n_checks++; if (ones !== 32) begin n_fail++; $display("FAIL period64_duty: got %0d expected 32", ones); end
        step_obs(c);
        n_checks++; if (c !== 63) begin n_fail++; $display("FAIL code63: got %0d expected 63", c); end
    endtask

    // From 63: target 60, after two down ticks retarget to 70, no overshoot
    task automatic test_reverse();
        int seq[$];
        int expv[$];
        int last, maxc, acks, c, serr;
        last = 63; maxc = 63; acks = 0;
        code_in = 8'd60; code_load = 1'b1;
        step_obs(c);
        if (code_ack === 1'b1) acks++;
        code_load = 1'b0;
        if (c != last) begin seq.push_back(c); last = c; end
        for (int k = 0; k < 40 && last != 61; k++) begin
            step_obs(c);
            if (code_ack === 1'b1) acks++;
            if (c != last) begin seq.push_back(c); last = c; end
            if (c > maxc) maxc = c;
        end
        code_in = 8'd70; code_load = 1'b1;
        step_obs(c);
        if (code_ack === 1'b1) acks++;
        code_load = 1'b0;
        if (c != last) begin seq.push_back(c); last = c; end
        for (int k = 0; k < 100; k++) begin
            step_obs(c);
            if (code_ack === 1'b1) acks++;
            if (c != last) begin seq.push_back(c); last = c; end
            if (c > maxc) maxc = c;
            if (lock === 1'b1) break;
        end
        for (int k = 0; k < 20; k++) begin
            step_obs(c);
            if (code_ack === 1'b1) acks++;
            if (c != last) begin seq.push_back(c); last = c; end
            if (c > maxc) maxc = c;
        end
        expv.push_back(62);
        expv.push_back(61);
        for (int v = 62; v <= 70; v++) expv.push_back(v);
        n_checks++; if (seq.size() !== expv.size()) begin n_fail++; $display("FAIL reverse_len: got %0d expected %0d", seq.size(), expv.size()); end
        serr = 0;
        for (int i = 0; i < seq.size() && i < expv.size(); i++) if (seq[i] !== expv[i]) serr++;
        n_checks++; if (serr !== 0) begin n_fail++; $display("FAIL reverse_seq: got %0d wrong steps expected 0", serr); end
        n_checks++; if (maxc !== 70) begin n_fail++; $display("FAIL reverse_overshoot: got max %0d expected 70", maxc); end
        n_checks++; if (acks !== 2) begin n_fail++; $display("FAIL reverse_acks: got %0d expected 2", acks); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL reverse_lock: got %b expected 1", lock); end
    endtask

    // Disable mid-slew at cur=20/target=40; loads ignored; slew resumes from 20
    task automatic test_idle();
        int c, found, ierr, iacks;
        ena = 1'b1; code_in = 8'd40; code_load = 1'b1;
        tick();
        code_load = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            step_obs(c);
            if (c == 20) begin found = 1; break; end
        end
        n_checks++; if (found !== 1) begin n_fail++; $display("FAIL idle_reach20: got %0d expected 1", found); end
        ena = 1'b0; code_in = 8'd5; code_load = 1'b1;
        ierr = 0; iacks = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (phase !== 12'd0 || dco_out !== 1'b0 || wrap !== 1'b0) ierr++;
            if (code_ack !== 1'b0) iacks++;
        end
        n_checks++; if (ierr !== 0) begin n_fail++; $display("FAIL idle_outputs: got %0d bad cycles expected 0", ierr); end
        n_checks++; if (iacks !== 0) begin n_fail++; $display("FAIL idle_ack: got %0d expected 0", iacks); end
        code_load = 1'b0; ena = 1'b1;
        tick();
        n_checks++; if (phase !== 12'd21) begin n_fail++; $display("FAIL idle_resume_phase: got %0d expected 21", phase); end
        for (int k = 0; k < 200; k++) begin
            step_obs(c);
            if (lock === 1'b1) break;
        end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL idle_relock: got %b expected 1", lock); end
        n_checks++; if (c !== 40) begin n_fail++; $display("FAIL idle_target_kept: got %0d expected 40", c); end
    endtask

    // Asynchronous reset mid-cycle while slewing clears outputs without a clock edge
    task automatic test_async_reset();
        ena = 1'b1; code_in = 8'd100; code_load = 1'b1;
        tick();
        code_load = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (phase !== 12'd0) begin n_fail++; $display("FAIL arst_phase: got %0d expected 0", phase); end
        n_checks++; if (dco_out !== 1'b0) begin n_fail++; $display("FAIL arst_dco: got %b expected 0", dco_out); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL arst_lock: got %b expected 1", lock); end
        n_checks++; if (code_ack !== 1'b0 || wrap !== 1'b0) begin n_fail++; $display("FAIL arst_strobes: got ack=%b wrap=%b expected 0 0", code_ack, wrap); end
        ena = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        test_free_run("post_arst");
    endtask

`ifdef DCO_DITHER_EN
    // Dither at code 63: mean wrap interval strictly between 63 and 64 clocks
    task automatic test_dither();
        int found, wraps, cycles, c, perr, berr;
        int bits[$];
        ena = 1'b1; code_in = 8'd63; code_load = 1'b1;
        tick();
        code_load = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (lock === 1'b1) break;
        end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL dither_lock: got %b expected 1", lock); end
        found = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (wrap === 1'b1) begin found = 1; break; end
        end
        wraps = 0; cycles = 0;
        for (int k = 0; k < 5000 && wraps < 64; k++) begin
            tick();
            cycles++;
            if (wrap === 1'b1) wraps++;
        end
        n_checks++; if (wraps !== 64 || cycles <= 4032 || cycles >= 4096) begin n_fail++; $display("FAIL dither_interval: got %0d clocks for %0d wraps expected 4033..4095 for 64", cycles, wraps); end
        berr = 0;
        for (int k = 0; k < 510; k++) begin
            step_obs(c);
            if (c != 63 && c != 64) berr++;
            bits.push_back(c - 63);
        end
        perr = 0;
        for (int i = 0; i < 255; i++) if (bits[i] !== bits[i + 255]) perr++;
        n_checks++; if (berr !== 0) begin n_fail++; $display("FAIL dither_inc: got %0d bad increments expected 0", berr); end
        n_checks++; if (perr !== 0) begin n_fail++; $display("FAIL dither_period: got %0d differing bits expected 0", perr); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run("free_run");
        test_load_slew();
        test_reverse();
        test_reset();
        test_idle();
        test_reset();
        test_async_reset();
`ifdef DCO_DITHER_EN
        test_reset();
        test_dither();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
